// File: rtl/wave_vis_pkg.sv
// Constants and types shared by the waveform capture buffer and the VGA waveform renderer.
package wave_vis_pkg;

    localparam int WAVE_DEPTH = 160;
    localparam int WAVE_AMP_W = 6;
    localparam int WAVE_IDX_W = 8;

    // Screen geometry: each captured column spans WAVE_X_SCALE pixels, centred on WAVE_Y_CENTER.
    localparam int SCREEN_W      = 640;
    localparam int SCREEN_H      = 480;
    localparam int WAVE_X_SCALE  = SCREEN_W / WAVE_DEPTH;
    localparam int WAVE_Y_CENTER = SCREEN_H / 2;
    localparam int WAVE_Y_SCALE  = 4;

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } wave_state_e;

endpackage

// File: rtl/wave_capture_ram.sv
// Ping-pong waveform store: two DEPTH-entry banks with a synchronous write port and a
// registered read port that returns zero whenever the read is not enabled.
module wave_capture_ram
    import wave_vis_pkg::*;
#(
    parameter int DEPTH = WAVE_DEPTH,
    parameter int WIDTH = WAVE_AMP_W,
    parameter int IDX_W = WAVE_IDX_W
) (
    input  logic             clk,
    input  logic             srst_i,
    input  logic             wr_en_i,
    input  logic             wr_bank_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic             rd_bank_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam int ADDR_W = $clog2(2 * DEPTH);

    logic [WIDTH-1:0] mem_q [0:2*DEPTH-1];
    logic [WIDTH-1:0] rd_data_q;

    function automatic logic [ADDR_W-1:0] flat_addr(input logic bank, input logic [IDX_W-1:0] idx);
        return bank ? (ADDR_W'(DEPTH) + ADDR_W'(idx)) : ADDR_W'(idx);
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[flat_addr(wr_bank_i, wr_idx_i)] <= wr_data_i;
        end
    end

    // Contents are never cleared; the output register masks them until a bank is valid.
    always_ff @(posedge clk) begin
        if (srst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[flat_addr(rd_bank_i, rd_idx_i)];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/wave_capture_buffer.sv
// Decimates and scales audio into a 160-column ping-pong window for the waveform display.
// Define WAVE_CAPTURE_TRIGGER_EN for rising zero-crossing trigger with forced timeout trigger.
module wave_capture_buffer
    import wave_vis_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int DEPTH    = WAVE_DEPTH,
    parameter int TIMEOUT  = 2048
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SAMPLE_W-1:0]   sample_in,
    input  logic                  sample_valid,
    input  logic [7:0]            decimation,
    input  logic                  frame_done,
    input  logic [WAVE_IDX_W-1:0] wave_requested,
    output logic [WAVE_AMP_W-1:0] wave_amplitude,
    output logic                  capturing
);

    localparam int AMP_LSB = SAMPLE_W - WAVE_AMP_W;
    localparam logic [WAVE_IDX_W-1:0] LAST_IDX  = WAVE_IDX_W'(DEPTH - 1);
    localparam logic [WAVE_IDX_W-1:0] DEPTH_IDX = WAVE_IDX_W'(DEPTH);

    wave_state_e           state_q;
    logic [7:0]            dec_cnt_q;
    logic [WAVE_IDX_W-1:0] wr_idx_q;
    logic                  buf_sel_q;
    logic                  front_valid_q;
    logic                  capturing_q;

    logic                  kept;
    logic                  trigger;
    logic                  wr_en;
    logic [WAVE_IDX_W-1:0] wr_addr;
    logic [WAVE_AMP_W-1:0] amp;
    logic                  rd_en;
    logic                  unused_bits;

    assign amp         = sample_in[SAMPLE_W-1 -: WAVE_AMP_W];
    assign unused_bits = ^sample_in[AMP_LSB-1:0];
    assign kept        = sample_valid && (dec_cnt_q == 8'd0);

`ifdef WAVE_CAPTURE_TRIGGER_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic            prev_neg_q;
    logic [TO_W-1:0] timeout_q;

    assign trigger = kept && ((!amp[WAVE_AMP_W-1] && prev_neg_q) || (timeout_q == TO_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_neg_q <= 1'b0;
            timeout_q  <= '0;
        end else begin
            if (kept) begin
                prev_neg_q <= amp[WAVE_AMP_W-1];
            end
            if ((state_q != ST_ARMED) || trigger) begin
                timeout_q <= '0;
            end else if (kept) begin
                timeout_q <= timeout_q + TO_W'(1);
            end
        end
    end
`else
    logic unused_cfg;

    // Free-running capture: the first kept sample after arming starts the window.
    assign trigger    = kept;
    assign unused_cfg = (TIMEOUT != 0);
`endif

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = wr_idx_q;
        case (state_q)
            ST_ARMED: begin
                wr_en   = trigger;
                wr_addr = '0;
            end
            ST_CAPTURE: wr_en = kept;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_ARMED;
            dec_cnt_q     <= 8'd0;
            wr_idx_q      <= '0;
            buf_sel_q     <= 1'b0;
            front_valid_q <= 1'b0;
            capturing_q   <= 1'b0;
        end else begin
            // A new decimation value is only picked up at the reload.
            if (sample_valid) begin
                dec_cnt_q <= (dec_cnt_q == 8'd0) ? decimation : (dec_cnt_q - 8'd1);
            end
            case (state_q)
                ST_ARMED: begin
                    if (trigger) begin
                        state_q     <= ST_CAPTURE;
                        capturing_q <= 1'b1;
                        wr_idx_q    <= WAVE_IDX_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (kept) begin
                        if (wr_idx_q == LAST_IDX) begin
                            state_q     <= ST_DONE;
                            capturing_q <= 1'b0;
                            wr_idx_q    <= '0;
                        end else begin
                            wr_idx_q <= wr_idx_q + WAVE_IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // Swap only here, so a frame never shows a half-written window.
                    if (frame_done) begin
                        state_q       <= ST_ARMED;
                        buf_sel_q     <= ~buf_sel_q;
                        front_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_ARMED;
                    capturing_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_en = front_valid_q && (wave_requested < DEPTH_IDX);

    wave_capture_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WAVE_AMP_W),
        .IDX_W (WAVE_IDX_W)
    ) u_ram (
        .clk       (clk),
        .srst_i    (reset),
        .wr_en_i   (wr_en),
        .wr_bank_i (~buf_sel_q),
        .wr_idx_i  (wr_addr),
        .wr_data_i (amp),
        .rd_en_i   (rd_en),
        .rd_bank_i (buf_sel_q),
        .rd_idx_i  (wave_requested),
        .rd_data_o (wave_amplitude)
    );

    assign capturing = capturing_q;

endmodule

// File: tb/tb_wave_capture_buffer.sv
// Directed bench for wave_capture_buffer; expectations follow the WAVE_CAPTURE_TRIGGER_EN setting.
module tb_wave_capture_buffer;

`ifdef WAVE_CAPTURE_TRIGGER_EN
    localparam bit TRIG_EN = 1'b1;
`else
    localparam bit TRIG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [7:0]  decimation;
    logic        frame_done;
    logic [7:0]  wave_requested;
    logic [5:0]  wave_amplitude;
    logic        capturing;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] col;
        int         exp_amp;
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    wave_capture_buffer dut (
        .clk            (clk),
        .reset          (reset),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .decimation     (decimation),
        .frame_done     (frame_done),
        .wave_requested (wave_requested),
        .wave_amplitude (wave_amplitude),
        .capturing      (capturing)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int amp_now();
        return int'($signed(wave_amplitude));
    endfunction

    task automatic check(input string name, input int got, input int exp_val);
        n_vec++;
        if (got !== exp_val) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp_val);
        end
    endtask

    task automatic strobe(input int v, input logic fd);
        sample_in    = v[15:0];
        sample_valid = 1'b1;
        frame_done   = fd;
        tick();
        sample_valid = 1'b0;
        frame_done   = 1'b0;
        sample_in    = 16'h8000;
    endtask

    task automatic check_col(input string name, input int c, input int exp_val);
        wave_requested = c[7:0];
        tick();
        check(name, amp_now(), exp_val);
    endtask

    task automatic pulse_fd();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fill;
        int pre;

`ifdef WAVE_CAPTURE_TRIGGER_EN
        tbl[0]  = '{8'd0,   2};
        tbl[1]  = '{8'd1,   3};
        tbl[2]  = '{8'd2,   4};
        tbl[3]  = '{8'd29,  31};
        tbl[4]  = '{8'd30,  0};
        tbl[5]  = '{8'd31,  1};
        tbl[6]  = '{8'd100, 6};
        tbl[7]  = '{8'd159, 1};
`else
        tbl[0]  = '{8'd0,   -1};
        tbl[1]  = '{8'd1,   2};
        tbl[2]  = '{8'd2,   3};
        tbl[3]  = '{8'd29,  30};
        tbl[4]  = '{8'd30,  31};
        tbl[5]  = '{8'd31,  0};
        tbl[6]  = '{8'd100, 5};
        tbl[7]  = '{8'd159, 0};
`endif
        tbl[8]  = '{8'd160, 0};
        tbl[9]  = '{8'd200, 0};
        tbl[10] = '{8'd255, 0};

        fill = TRIG_EN ? 160 : 159;
        pre  = TRIG_EN ? 80 : 79;

        reset          = 1'b1;
        sample_in      = '0;
        sample_valid   = 1'b0;
        decimation     = 8'd0;
        frame_done     = 1'b0;
        wave_requested = 8'd0;
        tick();
        tick();
        check("reset_capturing", int'(capturing), 0);
        check("reset_amp", amp_now(), 0);
        reset = 1'b0;
        tick();

        // Nothing captured yet: every column masked.
        for (int c = 0; c < 160; c++) begin
            check_col($sformatf("reset_col%0d", c), c, 0);
        end
        check("idle_capturing", int'(capturing), 0);

        // Zero-crossing capture, decimation 0.
        strobe(-1024, 1'b0);
        check("zc_arm_capturing", int'(capturing), TRIG_EN ? 0 : 1);
        strobe(2048, 1'b0);
        check("zc_trig_capturing", int'(capturing), 1);
        for (int k = 1; k < 160; k++) begin
            strobe(((k + 2) % 32) * 1024, 1'b0);
        end
        check("zc_done_capturing", int'(capturing), 0);
        check_col("zc_pre_swap_col0", 0, 0);
        pulse_fd();
        for (int i = 0; i < 11; i++) begin
            check_col($sformatf("zc_col%0d", tbl[i].col), int'(tbl[i].col), tbl[i].exp_amp);
        end

        // Decimation 3 with idle cycles between strobes carrying junk data.
        decimation = 8'd3;
        for (int j = 0; j <= 640; j++) begin
            strobe((j == 0) ? -1024 : (j % 32) * 1024, 1'b0);
            tick();
        end
        check("dec_done_capturing", int'(capturing), 0);
        pulse_fd();
        check_col("dec_col0",   0,   TRIG_EN ? 4 : -1);
        check_col("dec_col1",   1,   TRIG_EN ? 8 : 4);
        check_col("dec_col5",   5,   TRIG_EN ? 24 : 20);
        check_col("dec_col10",  10,  TRIG_EN ? 12 : 8);
        check_col("dec_col159", 159, TRIG_EN ? 0 : 28);

        // Constant positive input: forced trigger on the 2048th kept sample.
        decimation = 8'd0;
        do_reset();
        for (int n = 1; n <= 2207; n++) begin
            strobe(20000, 1'b0);
            if (n == 2047) check("to_before_capturing", int'(capturing), 0);
            if (n == 2048) check("to_forced_capturing", int'(capturing), TRIG_EN ? 1 : 0);
        end
        check("to_done_capturing", int'(capturing), 0);
        pulse_fd();
        for (int c = 0; c < 160; c++) begin
            check_col($sformatf("to_col%0d", c), c, 19);
        end

        // frame_done mid-capture and on the final write must not swap.
        strobe(-1024, 1'b0);
        for (int n = 1; n <= fill; n++) begin
            strobe(7 * 1024, (n == 50) || (n == fill));
        end
        check("fd_final_capturing", int'(capturing), 0);
        check_col("fd_hold_col0", 0, 19);
        check_col("fd_hold_col5", 5, 19);
        pulse_fd();
        check_col("fd_swap_col0",   0,   TRIG_EN ? 7 : -1);
        check_col("fd_swap_col5",   5,   7);
        check_col("fd_swap_col159", 159, 7);
        check_col("fd_swap_col200", 200, 0);
        pulse_fd();
        check_col("fd_armed_col5", 5, 7);

        // Reset at wr_idx 80 abandons the window, then a clean capture.
        strobe(-1024, 1'b0);
        for (int n = 1; n <= pre; n++) begin
            strobe(9 * 1024, 1'b0);
        end
        check("rst_mid_capturing_before", int'(capturing), 1);
        reset = 1'b1;
        tick();
        check("rst_mid_capturing", int'(capturing), 0);
        reset = 1'b0;
        check_col("rst_mid_col0",  0,  0);
        check_col("rst_mid_col80", 80, 0);
        strobe(-1024, 1'b0);
        for (int n = 1; n <= fill; n++) begin
            strobe(11 * 1024, 1'b0);
        end
        check("rst_new_done_capturing", int'(capturing), 0);
        pulse_fd();
        check_col("rst_new_col0",   0,   TRIG_EN ? 11 : -1);
        check_col("rst_new_col1",   1,   11);
        check_col("rst_new_col80",  80,  11);
        check_col("rst_new_col159", 159, 11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
